// File: rtl/cpu_cache_engine.sv
// cpu_cache_engine: CPU-side requester with an internal WAYS-way set-associative
// MESI cache. Program-port requests are looked up locally. Misses, dirty-victim
// write-backs and store write-throughs go to the memory controller over the
// req_CPU/gnt_CPU handshake.

package cpu_cache_pkg;
    typedef enum logic [1:0] {
        INV = 2'd0,
        SHD = 2'd1,
        EXC = 2'd2,
        MOD = 2'd3
    } Tmesi_state;
endpackage

// Assertion checker: a lookup may never hit in more than one way of a set.
module cpu_cache_engine_chk #(
    parameter int WAYS = 2
) (
    input logic            clk,
    input logic            reset,
    input logic            lookup_i,
    input logic [WAYS-1:0] hit_i
);
    a_single_hit: assert property (@(posedge clk) disable iff (reset) lookup_i |-> $onehot0(hit_i));
endmodule

module cpu_cache_engine
    import cpu_cache_pkg::*;
#(
    parameter int IDX_W  = 8,
    parameter int TAG_W  = 8,
    parameter int DATA_W = 32,
    parameter int WAYS   = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_valid,
    output logic                    cpu_ready,
    input  logic                    cpu_we,
    input  logic [TAG_W+IDX_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]       cpu_wdata,
    output logic                    rsp_valid,
    output logic                    rsp_hit,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    req_CPU,
    input  logic                    gnt_CPU,
    output logic [TAG_W+IDX_W-1:0]  addr_from_program,
    output logic                    we_to_mm,
    output logic [DATA_W-1:0]       wdata_to_memory,
    input  logic                    read_mm_completed,
    input  logic [DATA_W-1:0]       data_from_memory,
    input  Tmesi_state              rd_mesi_state,
    output logic [CNT_W-1:0]        hit_cnt,
    output logic [CNT_W-1:0]        miss_cnt
);
    localparam int ADDR_W = TAG_W + IDX_W;
    localparam int SETS   = 1 << IDX_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOOKUP   = 3'd1,
        S_RESP     = 3'd2,
        S_WB_REQ   = 3'd3,
        S_WB_WAIT  = 3'd4,
        S_MEM_REQ  = 3'd5,
        S_MEM_WAIT = 3'd6,
        S_FILL     = 3'd7
    } state_t;

    // Saturating statistics increment: all-ones is sticky.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Cache storage: state array is reset, tag/data behave like plain memories.
    Tmesi_state        mesi_q     [SETS][WAYS];
    logic [TAG_W-1:0]  tag_mem_q  [SETS][WAYS];
    logic [DATA_W-1:0] data_mem_q [SETS][WAYS];
    logic [WAY_W-1:0]  rr_q       [SETS];

    state_t            state_q, state_d;
    logic              req_we_q, req_we_d;
    logic [TAG_W-1:0]  req_tag_q, req_tag_d;
    logic [IDX_W-1:0]  req_idx_q, req_idx_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic [DATA_W-1:0] fill_data_q, fill_data_d;
    Tmesi_state        fill_state_q, fill_state_d;
    logic              hit_flag_q, hit_flag_d;

    logic              cpu_ready_q, cpu_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_hit_q, rsp_hit_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic              mwe_q, mwe_d;
    logic [DATA_W-1:0] mwdata_q, mwdata_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

    logic [WAYS-1:0]   hit_vec_s;
    logic              hit_s;
    logic [WAY_W-1:0]  hit_way_s;
    logic              any_inv_s;
    logic [WAY_W-1:0]  inv_way_s;
    logic [WAY_W-1:0]  vic_way_s;
    Tmesi_state        hit_state_s;
    Tmesi_state        vic_state_s;
    logic [WAY_W-1:0]  rr_cur_s;
    logic [WAY_W-1:0]  rr_next_s;
    logic              rr_we_s;
    logic              wr_en_s;
    logic [WAY_W-1:0]  wr_way_s;
    logic [DATA_W-1:0] wr_data_s;
    Tmesi_state        wr_state_s;
    logic              lookup_s;

    // Way compare for the registered request, plus lowest-numbered invalid way.
    always_comb begin
        hit_vec_s = '0;
        hit_way_s = '0;
        any_inv_s = 1'b0;
        inv_way_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec_s[w] = (mesi_q[req_idx_q][w] != INV) && (tag_mem_q[req_idx_q][w] == req_tag_q);
            hit_way_s    = hit_vec_s[w] ? WAY_W'(w) : hit_way_s;
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            inv_way_s = (mesi_q[req_idx_q][w] == INV) ? WAY_W'(w) : inv_way_s;
            any_inv_s = any_inv_s | (mesi_q[req_idx_q][w] == INV);
        end
    end

    assign hit_s       = |hit_vec_s;
    assign hit_state_s = mesi_q[req_idx_q][hit_way_s];
    assign rr_cur_s    = rr_q[req_idx_q];
    assign rr_next_s   = (rr_cur_s == WAY_W'(WAYS - 1)) ? '0 : rr_cur_s + WAY_W'(1);
    assign vic_way_s   = any_inv_s ? inv_way_s : rr_cur_s;
    assign vic_state_s = mesi_q[req_idx_q][vic_way_s];
    assign lookup_s    = (state_q == S_LOOKUP);

    // Next-state, array-write and output-register logic of the request FSM.
    always_comb begin
        state_d      = state_q;
        req_we_d     = req_we_q;
        req_tag_d    = req_tag_q;
        req_idx_d    = req_idx_q;
        req_wdata_d  = req_wdata_q;
        victim_d     = victim_q;
        fill_data_d  = fill_data_q;
        fill_state_d = fill_state_q;
        hit_flag_d   = hit_flag_q;
        rsp_valid_d  = 1'b0;
        rsp_hit_d    = 1'b0;
        rsp_data_d   = '0;
        maddr_d      = maddr_q;
        mwe_d        = mwe_q;
        mwdata_d     = mwdata_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        rr_we_s      = 1'b0;
        wr_en_s      = 1'b0;
        wr_way_s     = '0;
        wr_data_s    = '0;
        wr_state_s   = INV;
        case (state_q)
            S_IDLE: begin
                if (cpu_valid && cpu_ready_q) begin
                    req_we_d    = cpu_we;
                    req_tag_d   = cpu_addr[ADDR_W-1:IDX_W];
                    req_idx_d   = cpu_addr[IDX_W-1:0];
                    req_wdata_d = cpu_wdata;
                    state_d     = S_LOOKUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOOKUP: begin
                if (hit_s) begin
                    hit_cnt_d = sat_inc(hit_cnt_q);
                end else begin
                    miss_cnt_d = sat_inc(miss_cnt_q);
                end
                if (hit_s && req_we_q) begin
                    // Store hit: update the line; shared lines also write through.
                    wr_en_s    = 1'b1;
                    wr_way_s   = hit_way_s;
                    wr_data_s  = req_wdata_q;
                    wr_state_s = (hit_state_s == SHD) ? SHD : MOD;
                    if (hit_state_s == SHD) begin
                        hit_flag_d = 1'b1;
                        maddr_d    = {req_tag_q, req_idx_q};
                        mwe_d      = 1'b1;
                        mwdata_d   = req_wdata_q;
                        state_d    = S_MEM_REQ;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_hit_d   = 1'b1;
                        state_d     = S_RESP;
                    end
                end else if (hit_s) begin
                    rsp_valid_d = 1'b1;
                    rsp_hit_d   = 1'b1;
                    rsp_data_d  = data_mem_q[req_idx_q][hit_way_s];
                    state_d     = S_RESP;
                end else if (req_we_q) begin
                    // Store miss: write through without allocating.
                    hit_flag_d = 1'b0;
                    maddr_d    = {req_tag_q, req_idx_q};
                    mwe_d      = 1'b1;
                    mwdata_d   = req_wdata_q;
                    state_d    = S_MEM_REQ;
                end else begin
                    // Load miss: choose a victim, flushing it first when dirty.
                    victim_d = vic_way_s;
                    rr_we_s  = !any_inv_s;
                    if (vic_state_s == MOD) begin
                        maddr_d  = {tag_mem_q[req_idx_q][vic_way_s], req_idx_q};
                        mwe_d    = 1'b1;
                        mwdata_d = data_mem_q[req_idx_q][vic_way_s];
                        state_d  = S_WB_REQ;
                    end else begin
                        maddr_d  = {req_tag_q, req_idx_q};
                        mwe_d    = 1'b0;
                        mwdata_d = '0;
                        state_d  = S_MEM_REQ;
                    end
                end
            end
            S_WB_REQ: begin
                state_d = gnt_CPU ? S_WB_WAIT : S_WB_REQ;
            end
            S_WB_WAIT: begin
                if (read_mm_completed) begin
                    maddr_d  = {req_tag_q, req_idx_q};
                    mwe_d    = 1'b0;
                    mwdata_d = '0;
                    state_d  = S_MEM_REQ;
                end else begin
                    state_d = S_WB_WAIT;
                end
            end
            S_MEM_REQ: begin
                state_d = gnt_CPU ? S_MEM_WAIT : S_MEM_REQ;
            end
            S_MEM_WAIT: begin
                if (read_mm_completed) begin
                    maddr_d  = '0;
                    mwe_d    = 1'b0;
                    mwdata_d = '0;
                    if (req_we_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_hit_d   = hit_flag_q;
                        state_d     = S_RESP;
                    end else begin
                        // A fill may only install a clean state.
                        fill_data_d  = data_from_memory;
                        fill_state_d = (rd_mesi_state == EXC || rd_mesi_state == SHD) ? rd_mesi_state : SHD;
                        state_d      = S_FILL;
                    end
                end else begin
                    state_d = S_MEM_WAIT;
                end
            end
            S_FILL: begin
                wr_en_s     = 1'b1;
                wr_way_s    = victim_q;
                wr_data_s   = fill_data_q;
                wr_state_s  = fill_state_q;
                rsp_valid_d = 1'b1;
                rsp_hit_d   = 1'b0;
                rsp_data_d  = fill_data_q;
                state_d     = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        cpu_ready_d = (state_d == S_IDLE);
        req_d       = (state_d == S_WB_REQ) || (state_d == S_WB_WAIT) ||
                      (state_d == S_MEM_REQ) || (state_d == S_MEM_WAIT);
    end

    // FSM state, request capture and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            req_we_q     <= 1'b0;
            req_tag_q    <= '0;
            req_idx_q    <= '0;
            req_wdata_q  <= '0;
            victim_q     <= '0;
            fill_data_q  <= '0;
            fill_state_q <= INV;
            hit_flag_q   <= 1'b0;
            cpu_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_data_q   <= '0;
            req_q        <= 1'b0;
            maddr_q      <= '0;
            mwe_q        <= 1'b0;
            mwdata_q     <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            req_we_q     <= req_we_d;
            req_tag_q    <= req_tag_d;
            req_idx_q    <= req_idx_d;
            req_wdata_q  <= req_wdata_d;
            victim_q     <= victim_d;
            fill_data_q  <= fill_data_d;
            fill_state_q <= fill_state_d;
            hit_flag_q   <= hit_flag_d;
            cpu_ready_q  <= cpu_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_hit_q    <= rsp_hit_d;
            rsp_data_q   <= rsp_data_d;
            req_q        <= req_d;
            maddr_q      <= maddr_d;
            mwe_q        <= mwe_d;
            mwdata_q     <= mwdata_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // Line states and round-robin pointers: cleared on reset, updated on lookup/fill.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    mesi_q[s][w] <= INV;
                end
            end
        end else begin
            if (wr_en_s) begin
                mesi_q[req_idx_q][wr_way_s] <= wr_state_s;
            end
            if (rr_we_s) begin
                rr_q[req_idx_q] <= rr_next_s;
            end
        end
    end

    // Tag and data arrays; writes are suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (wr_en_s && !reset) begin
            tag_mem_q[req_idx_q][wr_way_s]  <= req_tag_q;
            data_mem_q[req_idx_q][wr_way_s] <= wr_data_s;
        end
    end

    assign cpu_ready         = cpu_ready_q;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_hit           = rsp_hit_q;
    assign rsp_data          = rsp_data_q;
    assign req_CPU           = req_q;
    assign addr_from_program = maddr_q;
    assign we_to_mm          = mwe_q;
    assign wdata_to_memory   = mwdata_q;
    assign hit_cnt           = hit_cnt_q;
    assign miss_cnt          = miss_cnt_q;

    cpu_cache_engine_chk #(.WAYS(WAYS)) u_chk (
        .clk      (clk),
        .reset    (reset),
        .lookup_i (lookup_s),
        .hit_i    (hit_vec_s)
    );
endmodule

// File: tb/tb_cpu_cache_engine.sv
// Directed testbench for cpu_cache_engine: the bench acts as CPU and memory
// controller, and every expected value is hand-computed.
module tb_cpu_cache_engine;
    import cpu_cache_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_valid = 1'b0;
    logic        cpu_ready;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [31:0] cpu_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_hit;
    logic [31:0] rsp_data;
    logic        req_CPU;
    logic        gnt_CPU = 1'b0;
    logic [15:0] addr_from_program;
    logic        we_to_mm;
    logic [31:0] wdata_to_memory;
    logic        read_mm_completed = 1'b0;
    logic [31:0] data_from_memory = 32'h0;
    Tmesi_state  rd_mesi_state = INV;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    int n_vec = 0;
    int n_err = 0;

    cpu_cache_engine dut (
        .clk               (clk),
        .reset             (reset),
        .cpu_valid         (cpu_valid),
        .cpu_ready         (cpu_ready),
        .cpu_we            (cpu_we),
        .cpu_addr          (cpu_addr),
        .cpu_wdata         (cpu_wdata),
        .rsp_valid         (rsp_valid),
        .rsp_hit           (rsp_hit),
        .rsp_data          (rsp_data),
        .req_CPU           (req_CPU),
        .gnt_CPU           (gnt_CPU),
        .addr_from_program (addr_from_program),
        .we_to_mm          (we_to_mm),
        .wdata_to_memory   (wdata_to_memory),
        .read_mm_completed (read_mm_completed),
        .data_from_memory  (data_from_memory),
        .rd_mesi_state     (rd_mesi_state),
        .hit_cnt           (hit_cnt),
        .miss_cnt          (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [15:0] a, input logic [31:0] d);
        int n = 0;
        while (!cpu_ready && n < 20) begin
            step();
            n++;
        end
        check_val("cpu_ready", {31'd0, cpu_ready}, 32'd1);
        cpu_valid = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        step();
        cpu_valid = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 32'h0;
    endtask

    // Acts as the memory controller for one transfer, checking addr/we/data
    // both in the grant cycle and in the completion cycle.
    task automatic serve(input string nm, input logic exp_we, input logic [15:0] exp_addr,
                         input logic [31:0] exp_wd, input logic [31:0] rdata, input Tmesi_state mst);
        int n = 0;
        while (!req_CPU && n < 50) begin
            step();
            n++;
        end
        check_val({nm, "_req"}, {31'd0, req_CPU}, 32'd1);
        gnt_CPU = 1'b1;
        check_val({nm, "_addr_gnt"}, {16'd0, addr_from_program}, {16'd0, exp_addr});
        check_val({nm, "_we_gnt"}, {31'd0, we_to_mm}, {31'd0, exp_we});
        check_val({nm, "_wd_gnt"}, wdata_to_memory, exp_wd);
        step();
        gnt_CPU = 1'b0;
        step();
        check_val({nm, "_req_hold"}, {31'd0, req_CPU}, 32'd1);
        read_mm_completed = 1'b1;
        data_from_memory  = rdata;
        rd_mesi_state     = mst;
        check_val({nm, "_addr_cmp"}, {16'd0, addr_from_program}, {16'd0, exp_addr});
        check_val({nm, "_we_cmp"}, {31'd0, we_to_mm}, {31'd0, exp_we});
        check_val({nm, "_wd_cmp"}, wdata_to_memory, exp_wd);
        step();
        read_mm_completed = 1'b0;
        data_from_memory  = 32'h0;
        rd_mesi_state     = INV;
    endtask

    task automatic wait_rsp(input string nm, input logic exp_hit, input logic [31:0] exp_data);
        int n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        check_val({nm, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        check_val({nm, "_rsp_hit"}, {31'd0, rsp_hit}, {31'd0, exp_hit});
        check_val({nm, "_rsp_data"}, rsp_data, exp_data);
    endtask

    // Exact-latency hit: response must be on the second cycle after accept.
    task automatic hit_rsp(input string nm, input logic [31:0] exp_data);
        check_val({nm, "_lookup_req"}, {31'd0, req_CPU}, 32'd0);
        step();
        check_val({nm, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        check_val({nm, "_rsp_hit"}, {31'd0, rsp_hit}, 32'd1);
        check_val({nm, "_rsp_data"}, rsp_data, exp_data);
        check_val({nm, "_no_req"}, {31'd0, req_CPU}, 32'd0);
    endtask

    initial begin
        int pulses;
        // Reset behaviour
        step();
        step();
        check_val("rst_ready", {31'd0, cpu_ready}, 32'd0);
        check_val("rst_req", {31'd0, req_CPU}, 32'd0);
        check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("rst_addr", {16'd0, addr_from_program}, 32'd0);
        reset = 1'b0;
        step();
        check_val("idle_ready", {31'd0, cpu_ready}, 32'd1);
        check_val("rst_hit_cnt", {16'd0, hit_cnt}, 32'd0);
        check_val("rst_miss_cnt", {16'd0, miss_cnt}, 32'd0);

        // A grant with no request outstanding is ignored
        gnt_CPU = 1'b1;
        step();
        gnt_CPU = 1'b0;
        check_val("stray_gnt_req", {31'd0, req_CPU}, 32'd0);
        check_val("stray_gnt_ready", {31'd0, cpu_ready}, 32'd1);

        // Load miss 0x0105, filled EXC
        issue(1'b0, 16'h0105, 32'h0);
        serve("ld0105", 1'b0, 16'h0105, 32'h0, 32'hDEADBEEF, EXC);
        wait_rsp("ld0105", 1'b0, 32'hDEADBEEF);
        check_val("ld0105_req_off", {31'd0, req_CPU}, 32'd0);
        check_val("miss_cnt1", {16'd0, miss_cnt}, 32'd1);

        // Load hit 0x0105
        issue(1'b0, 16'h0105, 32'h0);
        hit_rsp("ld0105_hit", 32'hDEADBEEF);
        check_val("hit_cnt1", {16'd0, hit_cnt}, 32'd1);

        // Store hit on EXC line: silent, line becomes MOD
        issue(1'b1, 16'h0105, 32'h12345678);
        hit_rsp("st0105", 32'h0);
        check_val("hit_cnt2", {16'd0, hit_cnt}, 32'd2);

        // Load 0x0205 fills the invalid way 1
        issue(1'b0, 16'h0205, 32'h0);
        serve("ld0205", 1'b0, 16'h0205, 32'h0, 32'hAAAA0205, SHD);
        wait_rsp("ld0205", 1'b0, 32'hAAAA0205);

        // Load 0x0305 evicts way 0 (MOD 0x0105): write-back, then read; MOD fill -> SHD
        issue(1'b0, 16'h0305, 32'h0);
        serve("wb0105", 1'b1, 16'h0105, 32'h12345678, 32'h0, INV);
        serve("ld0305", 1'b0, 16'h0305, 32'h0, 32'hBBBB0305, MOD);
        wait_rsp("ld0305", 1'b0, 32'hBBBB0305);
        check_val("miss_cnt3", {16'd0, miss_cnt}, 32'd3);

        // Store hits on the (coerced) SHD line write through and keep it SHD
        issue(1'b1, 16'h0305, 32'hCAFEF00D);
        serve("st0305a", 1'b1, 16'h0305, 32'hCAFEF00D, 32'h0, INV);
        wait_rsp("st0305a", 1'b1, 32'h0);
        issue(1'b1, 16'h0305, 32'h0BADF00D);
        serve("st0305b", 1'b1, 16'h0305, 32'h0BADF00D, 32'h0, INV);
        wait_rsp("st0305b", 1'b1, 32'h0);
        issue(1'b0, 16'h0305, 32'h0);
        hit_rsp("ld0305_hit", 32'h0BADF00D);
        check_val("hit_cnt5", {16'd0, hit_cnt}, 32'd5);

        // Store miss: write-through without allocation
        issue(1'b1, 16'h0405, 32'h11112222);
        serve("st0405", 1'b1, 16'h0405, 32'h11112222, 32'h0, INV);
        wait_rsp("st0405", 1'b0, 32'h0);
        issue(1'b0, 16'h0405, 32'h0);
        serve("ld0405", 1'b0, 16'h0405, 32'h0, 32'h44440405, INV);
        wait_rsp("ld0405", 1'b0, 32'h44440405);
        check_val("miss_cnt5", {16'd0, miss_cnt}, 32'd5);

        // Reset while waiting for memory
        issue(1'b0, 16'h0707, 32'h0);
        step();
        check_val("rst_mid_req", {31'd0, req_CPU}, 32'd1);
        gnt_CPU = 1'b1;
        step();
        gnt_CPU = 1'b0;
        step();
        reset = 1'b1;
        step();
        check_val("rst_mid_req_off", {31'd0, req_CPU}, 32'd0);
        check_val("rst_mid_rsp", {31'd0, rsp_valid}, 32'd0);
        reset = 1'b0;
        read_mm_completed = 1'b1;
        data_from_memory  = 32'h77777777;
        rd_mesi_state     = EXC;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            read_mm_completed = 1'b0;
            data_from_memory  = 32'h0;
            rd_mesi_state     = INV;
            if (rsp_valid) pulses++;
        end
        check_val("late_cmp_no_rsp", pulses, 32'd0);
        check_val("rst_mid_counters", {hit_cnt, miss_cnt}, 32'd0);

        // Previously cached 0x0305 must now miss
        issue(1'b0, 16'h0305, 32'h0);
        step();
        check_val("post_rst_miss_req", {31'd0, req_CPU}, 32'd1);
        check_val("post_rst_miss_cnt", {16'd0, miss_cnt}, 32'd1);
        serve("ld0305_post", 1'b0, 16'h0305, 32'h0, 32'h55550305, EXC);
        wait_rsp("ld0305_post", 1'b0, 32'h55550305);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
